// File: rtl/branch_resolve_predict.sv
// Branch/jump resolution for the execute stage with a registered redirect,
// plus a direct-mapped bimodal history table of 2-bit saturating counters
// that fetch queries for direction predictions. Conditional mispredicts are
// counted in a saturating performance counter.
module branch_resolve_predict #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 16,
    parameter logic [1:0]  CTR_INIT    = 2'b01,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [XLEN-1:0]  fetch_pc,
    output logic             fetch_pred_taken,
    input  logic             ex_valid,
    input  logic [2:0]       ex_op,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic [XLEN-1:0]  ex_imm,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic             ex_pred_taken,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [XLEN-1:0]  link_data,
    output logic             link_valid,
    output logic             misalign_exc,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    localparam logic [2:0] OP_JAL  = 3'd0;
    localparam logic [2:0] OP_JALR = 3'd1;
    localparam logic [2:0] OP_BEQ  = 3'd2;
    localparam logic [2:0] OP_BNE  = 3'd3;
    localparam logic [2:0] OP_BLT  = 3'd4;
    localparam logic [2:0] OP_BGE  = 3'd5;
    localparam logic [2:0] OP_BLTU = 3'd6;
    localparam logic [2:0] OP_BGEU = 3'd7;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Counter table; bit 1 of each entry is the predicted direction.
    logic [1:0] bht_r [BHT_ENTRIES];

    logic [IDX_W-1:0] fetch_idx_s;
    logic [IDX_W-1:0] upd_idx_s;
    logic [XLEN-1:0]  fall_s;
    logic [XLEN-1:0]  jalr_sum_s;
    logic [XLEN-1:0]  target_s;
    logic [XLEN-1:0]  next_pc_s;
    logic             taken_s;
    logic             is_jump_s;
    logic             is_branch_s;
    logic             misalign_s;
    logic             mispred_s;
    logic             redirect_s;
    logic             link_s;
    logic             bht_upd_s;
    logic [1:0]       ctr_next_s;

    assign fetch_idx_s      = fetch_pc[IDX_W+1:2];
    assign upd_idx_s        = ex_pc[IDX_W+1:2];
    // Lookup reads the array before any same-cycle write lands.
    assign fetch_pred_taken = bht_r[fetch_idx_s][1];

    // Resolve target, direction and the resulting redirect/exception decisions.
    always_comb begin
        fall_s     = ex_pc + XLEN'(3'd4);
        jalr_sum_s = ex_rs1 + ex_imm;
        target_s   = ex_pc + ex_imm;
        taken_s    = 1'b0;
        is_jump_s  = 1'b0;
        case (ex_op)
            OP_JAL: begin
                taken_s   = 1'b1;
                is_jump_s = 1'b1;
            end
            OP_JALR: begin
                taken_s   = 1'b1;
                is_jump_s = 1'b1;
                target_s  = {jalr_sum_s[XLEN-1:1], 1'b0};
            end
            OP_BEQ:  taken_s = (ex_rs1 == ex_rs2);
            OP_BNE:  taken_s = (ex_rs1 != ex_rs2);
            OP_BLT:  taken_s = ($signed(ex_rs1) <  $signed(ex_rs2));
            OP_BGE:  taken_s = ($signed(ex_rs1) >= $signed(ex_rs2));
            OP_BLTU: taken_s = (ex_rs1 <  ex_rs2);
            OP_BGEU: taken_s = (ex_rs1 >= ex_rs2);
            default: taken_s = 1'b0;
        endcase

        is_branch_s = ex_valid && !is_jump_s;
        // A taken op with an unaligned target traps instead of redirecting.
        misalign_s  = ex_valid && taken_s && (target_s[1:0] != 2'b00);
        mispred_s   = is_branch_s && (taken_s != ex_pred_taken) && !misalign_s;
        redirect_s  = ex_valid && !misalign_s && (is_jump_s || mispred_s);
        link_s      = ex_valid && is_jump_s && !misalign_s;
        bht_upd_s   = is_branch_s && !misalign_s;

        if (taken_s) begin
            next_pc_s = target_s;
        end else begin
            next_pc_s = fall_s;
        end
    end

    // Saturating increment/decrement of the counter addressed by ex_pc.
    always_comb begin
        ctr_next_s = bht_r[upd_idx_s];
        if (taken_s) begin
            if (bht_r[upd_idx_s] != 2'b11) begin
                ctr_next_s = bht_r[upd_idx_s] + 2'b01;
            end else begin
                ctr_next_s = 2'b11;
            end
        end else begin
            if (bht_r[upd_idx_s] != 2'b00) begin
                ctr_next_s = bht_r[upd_idx_s] - 2'b01;
            end else begin
                ctr_next_s = 2'b00;
            end
        end
    end

    // Register the redirect, link and exception pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            link_valid     <= 1'b0;
            link_data      <= '0;
            misalign_exc   <= 1'b0;
        end else begin
            redirect_valid <= redirect_s;
            link_valid     <= link_s;
            misalign_exc   <= misalign_s;
            if (redirect_s || misalign_s) begin
                redirect_pc <= next_pc_s;
            end
            if (ex_valid && is_jump_s) begin
                link_data <= fall_s;
            end
        end
    end

    // Saturating count of resolved conditional mispredicts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mispredict_count <= '0;
        end else if (mispred_s && (mispredict_count != CNT_MAX)) begin
            mispredict_count <= mispredict_count + CNT_ONE;
        end
    end

    // Train the history table on every valid, aligned conditional branch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= CTR_INIT;
            end
        end else if (bht_upd_s) begin
            bht_r[upd_idx_s] <= ctr_next_s;
        end
    end

endmodule

// File: tb/tb_branch_resolve_predict.sv
// Bench for branch_resolve_predict: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the resolve rules.
module tb_branch_resolve_predict;

    logic        clk;
    logic        rst_n;
    logic [31:0] fetch_pc;
    logic        ex_valid;
    logic [2:0]  ex_op;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;
    logic        ex_pred_taken;

    logic        fetch_pred_taken, redirect_valid, link_valid, misalign_exc;
    logic [31:0] redirect_pc, link_data;
    logic [15:0] mispredict_count;

    logic        s_fetch_pred_taken, s_redirect_valid, s_link_valid, s_misalign_exc;
    logic [31:0] s_redirect_pc, s_link_data;
    logic [1:0]  s_mispredict_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int          bht_m [16];
    int          cnt_m, cnt2_m;
    logic        e_rv, e_lv, e_mis;
    logic [31:0] e_rpc, e_ld;
    logic        exp_fpred, obs_fpred;

    branch_resolve_predict dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .fetch_pred_taken(fetch_pred_taken), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pred_taken(ex_pred_taken), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .link_data(link_data), .link_valid(link_valid),
        .misalign_exc(misalign_exc), .mispredict_count(mispredict_count)
    );

    branch_resolve_predict #(.CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .fetch_pred_taken(s_fetch_pred_taken), .ex_valid(ex_valid), .ex_op(ex_op),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_pred_taken(ex_pred_taken), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .link_data(s_link_data), .link_valid(s_link_valid),
        .misalign_exc(s_misalign_exc), .mispredict_count(s_mispredict_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd16);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) bht_m[i] = 1;
        cnt_m = 0; cnt2_m = 0;
        e_rv = 1'b0; e_lv = 1'b0; e_mis = 1'b0;
    endtask

    // Apply the architectural rules of one execute-stage op to the model.
    task automatic model_step(input logic v, input logic [2:0] op,
                              input logic [31:0] pc, imm, rs1, rs2,
                              input logic pred);
        bit taken;
        logic [31:0] tgt;
        longint a, b;
        e_rv = 1'b0; e_lv = 1'b0; e_mis = 1'b0;
        if (!v) return;
        tgt = pc + imm;
        a = longint'($signed(rs1)); b = longint'($signed(rs2));
        case (op)
            3'd0: taken = 1'b1;
            3'd1: begin taken = 1'b1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
            3'd2: taken = (rs1 == rs2);
            3'd3: taken = (rs1 != rs2);
            3'd4: taken = (a < b);
            3'd5: taken = !(a < b);
            3'd6: taken = (longint'(rs1) < longint'(rs2));
            default: taken = !(longint'(rs1) < longint'(rs2));
        endcase
        if (taken && (tgt % 32'd4 != 32'd0)) begin
            e_mis = 1'b1; e_rpc = tgt;
            return;
        end
        if (op < 3'd2) begin
            e_rv = 1'b1; e_rpc = tgt; e_lv = 1'b1; e_ld = pc + 32'd4;
        end else begin
            if (taken) bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 3) ? 3 : bht_m[idx_of(pc)] + 1;
            else       bht_m[idx_of(pc)] = (bht_m[idx_of(pc)] == 0) ? 0 : bht_m[idx_of(pc)] - 1;
            if (taken != pred) begin
                e_rv  = 1'b1;
                e_rpc = taken ? tgt : pc + 32'd4;
                cnt_m  = (cnt_m  == 65535) ? 65535 : cnt_m + 1;
                cnt2_m = (cnt2_m == 3) ? 3 : cnt2_m + 1;
            end
        end
    endtask

    // Drive one cycle (called just after a rising edge); returns just after the next one.
    task automatic do_cycle(input logic v, input logic [2:0] op,
                            input logic [31:0] pc, imm, rs1, rs2,
                            input logic pred, input logic [31:0] fpc);
        ex_valid = v; ex_op = op; ex_pc = pc; ex_imm = imm;
        ex_rs1 = rs1; ex_rs2 = rs2; ex_pred_taken = pred; fetch_pc = fpc;
        #1;
        obs_fpred = fetch_pred_taken;
        exp_fpred = (bht_m[idx_of(fpc)] >= 2);
        model_step(v, op, pc, imm, rs1, rs2, pred);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ex_valid = 1'b0; ex_op = 3'd0; ex_pc = 32'd0; ex_imm = 32'd0;
        ex_rs1 = 32'd0; ex_rs2 = 32'd0; ex_pred_taken = 1'b0; fetch_pc = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({redirect_valid, link_valid, misalign_exc, fetch_pred_taken} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags got=%b want=0000",
                {redirect_valid, link_valid, misalign_exc, fetch_pred_taken});
        end
        n_tests++;
        if ({redirect_pc, link_data, mispredict_count} !== 80'd0) begin
            n_fail++; $display("FAIL reset_data rpc=%h ld=%h cnt=%0d want all 0",
                redirect_pc, link_data, mispredict_count);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_beq();
        do_cycle(1'b1, 3'd2, 32'h100, 32'h20, 32'd5, 32'd5, 1'b0, 32'h100);
        n_tests++;
        if (obs_fpred !== 1'b0) begin
            n_fail++; $display("FAIL same_cycle_pred got=%b want=0", obs_fpred);
        end
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
            n_fail++; $display("FAIL beq_redirect got=%b/%h want=1/00000120", redirect_valid, redirect_pc);
        end
        n_tests++;
        if (mispredict_count !== 16'd1) begin
            n_fail++; $display("FAIL beq_count got=%0d want=1", mispredict_count);
        end
        do_cycle(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h100);
        n_tests++;
        if (obs_fpred !== 1'b1) begin
            n_fail++; $display("FAIL bht_trained got=%b want=1", obs_fpred);
        end
        n_tests++;
        if (redirect_valid !== 1'b0 || link_valid !== 1'b0) begin
            n_fail++; $display("FAIL pulse_drop got=%b%b want=00", redirect_valid, link_valid);
        end
    endtask

    task automatic test_signed();
        do_cycle(1'b1, 3'd4, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0);
        n_tests++;
        if (redirect_valid !== 1'b0) begin
            n_fail++; $display("FAIL blt_signed got=%b want=0", redirect_valid);
        end
        do_cycle(1'b1, 3'd6, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h0);
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304) begin
            n_fail++; $display("FAIL bltu_unsigned got=%b/%h want=1/00000304", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_jalr();
        do_cycle(1'b1, 3'd1, 32'h200, 32'h0, 32'h1003, 32'h0, 1'b0, 32'h0);
        n_tests++;
        if ({misalign_exc, redirect_valid, link_valid} !== 3'b100 || redirect_pc !== 32'h1002) begin
            n_fail++; $display("FAIL jalr_misalign got=%b%b%b/%h want=100/00001002",
                misalign_exc, redirect_valid, link_valid, redirect_pc);
        end
        do_cycle(1'b1, 3'd1, 32'h200, 32'h0, 32'h1001, 32'h0, 1'b0, 32'h0);
        n_tests++;
        if ({misalign_exc, redirect_valid, link_valid} !== 3'b011 || redirect_pc !== 32'h1000
            || link_data !== 32'h204) begin
            n_fail++; $display("FAIL jalr_link got=%b%b%b/%h/%h want=011/00001000/00000204",
                misalign_exc, redirect_valid, link_valid, redirect_pc, link_data);
        end
    endtask

    task automatic test_wrap_sat();
        do_cycle(1'b1, 3'd2, 32'hFFFF_FFFC, 32'd8, 32'd7, 32'd7, 1'b0, 32'h0);
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4) begin
            n_fail++; $display("FAIL wrap_target got=%b/%h want=1/00000004", redirect_valid, redirect_pc);
        end
        repeat (4) do_cycle(1'b1, 3'd2, 32'h84, 32'h10, 32'd1, 32'd1, 1'b1, 32'h84);
        do_cycle(1'b1, 3'd3, 32'h84, 32'h10, 32'd1, 32'd1, 1'b1, 32'h84);
        n_tests++;
        if (obs_fpred !== 1'b1) begin
            n_fail++; $display("FAIL sat_high got=%b want=1", obs_fpred);
        end
        do_cycle(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h84);
        n_tests++;
        if (obs_fpred !== 1'b1) begin
            n_fail++; $display("FAIL sat_one_down got=%b want=1", obs_fpred);
        end
    endtask

    task automatic test_async_reset();
        do_cycle(1'b1, 3'd3, 32'h500, 32'h8, 32'd1, 32'd2, 1'b0, 32'h84);
        n_tests++;
        if (redirect_valid !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_pulse got=%b want=1", redirect_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (redirect_valid !== 1'b0 || mispredict_count !== 16'd0 || fetch_pred_taken !== 1'b0) begin
            n_fail++; $display("FAIL async_reset got=%b/%0d/%b want=0/0/0",
                redirect_valid, mispredict_count, fetch_pred_taken);
        end
        ex_valid = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_count_sat();
        for (int k = 1; k <= 5; k++) begin
            do_cycle(1'b1, 3'd3, 32'h400, 32'h8, 32'd3, 32'd9, 1'b0, 32'h0);
            n_tests++;
            if (s_mispredict_count !== ((k > 3) ? 2'd3 : 2'(k)) || mispredict_count !== 16'(k)) begin
                n_fail++; $display("FAIL count_sat k=%0d got=%0d/%0d want=%0d/%0d", k,
                    s_mispredict_count, mispredict_count, (k > 3) ? 3 : k, k);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] pc, imm, rs1, rs2, fpc;
        logic [2:0]  op;
        logic        v, pred;
        for (int n = 0; n < 300; n++) begin
            v   = ($urandom_range(0, 4) != 0);
            op  = 3'($urandom_range(0, 7));
            pc  = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 1) == 1) pc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            imm = $urandom;
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFC;
            rs1 = $urandom;
            rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom;
            pred = ($urandom_range(0, 1) == 1);
            fpc = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            do_cycle(v, op, pc, imm, rs1, rs2, pred, fpc);
            n_tests++;
            if (obs_fpred !== exp_fpred) begin
                n_fail++; $display("FAIL rnd_pred n=%0d got=%b want=%b", n, obs_fpred, exp_fpred);
            end
            n_tests++;
            if ({redirect_valid, link_valid, misalign_exc} !== {e_rv, e_lv, e_mis}) begin
                n_fail++; $display("FAIL rnd_flags n=%0d op=%0d got=%b%b%b want=%b%b%b", n, op,
                    redirect_valid, link_valid, misalign_exc, e_rv, e_lv, e_mis);
            end
            if (e_rv || e_mis) begin
                n_tests++;
                if (redirect_pc !== e_rpc) begin
                    n_fail++; $display("FAIL rnd_rpc n=%0d got=%h want=%h", n, redirect_pc, e_rpc);
                end
            end
            if (e_lv) begin
                n_tests++;
                if (link_data !== e_ld) begin
                    n_fail++; $display("FAIL rnd_link n=%0d got=%h want=%h", n, link_data, e_ld);
                end
            end
            n_tests++;
            if (mispredict_count !== 16'(cnt_m) || s_mispredict_count !== 2'(cnt2_m)) begin
                n_fail++; $display("FAIL rnd_count n=%0d got=%0d/%0d want=%0d/%0d", n,
                    mispredict_count, s_mispredict_count, cnt_m, cnt2_m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_beq();
        test_signed();
        test_jalr();
        test_wrap_sat();
        test_async_reset();
        test_count_sat();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
